// File: rtl/flex_pts_stream.sv
// flex_pts_stream: parallel-to-serial shifter with a one-word holding buffer.
// A word accepted into the holding register moves into the shift register as
// soon as the shifter is free, so words queued ahead of time stream out with
// no idle bit between them.
module flex_pts_stream #(
    parameter int NUM_BITS  = 8,
    parameter bit SHIFT_MSB = 1'b1,
    parameter bit IDLE_BIT  = 1'b1
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NUM_BITS-1:0] parallel_in,
    input  logic                shift_enable,
    input  logic                abort,
    output logic                serial_out,
    output logic                word_done,
    output logic                busy
);

    localparam int                  CNT_W    = $clog2(NUM_BITS + 1);
    localparam logic [CNT_W-1:0]    CNT_FULL = CNT_W'(NUM_BITS);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(1);
    localparam logic [NUM_BITS-1:0] SR_IDLE  = {NUM_BITS{IDLE_BIT}};

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t              state, state_n;
    logic [NUM_BITS-1:0] sr, sr_n;
    logic [NUM_BITS-1:0] hr, hr_n;
    logic                hr_full, hr_full_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [NUM_BITS-1:0] sr_shifted;
    logic                handshake;

    // The holding register is the only input buffer, so readiness is simply its emptiness.
    assign in_ready  = !hr_full;
    assign handshake = in_valid && in_ready;
    assign busy      = (state == SHIFT) || hr_full;

    // Shift toward whichever end drives the line, back-filling with the idle level.
    assign sr_shifted = SHIFT_MSB ? {sr[NUM_BITS-2:0], IDLE_BIT}
                                  : {IDLE_BIT, sr[NUM_BITS-1:1]};

    assign serial_out = (state == SHIFT) ? (SHIFT_MSB ? sr[NUM_BITS-1] : sr[0])
                                         : IDLE_BIT;

    assign word_done = (state == SHIFT) && (cnt == CNT_LAST) && shift_enable && !abort;

    // State register; reset leaves the line idle and the buffer empty.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= IDLE;
            sr      <= SR_IDLE;
            hr      <= '0;
            hr_full <= 1'b0;
            cnt     <= '0;
        end else begin
            state   <= state_n;
            sr      <= sr_n;
            hr      <= hr_n;
            hr_full <= hr_full_n;
            cnt     <= cnt_n;
        end
    end

    // Next-state logic: abort wins, otherwise buffer refill and shifting proceed together.
    always_comb begin
        state_n   = state;
        sr_n      = sr;
        hr_n      = hr;
        hr_full_n = hr_full;
        cnt_n     = cnt;

        if (abort) begin
            state_n   = IDLE;
            sr_n      = SR_IDLE;
            hr_full_n = 1'b0;
            cnt_n     = '0;
        end else begin
            if (handshake) begin
                hr_n      = parallel_in;
                hr_full_n = 1'b1;
            end

            case (state)
                IDLE: begin
                    if (hr_full) begin
                        sr_n      = hr;
                        hr_full_n = 1'b0;
                        cnt_n     = CNT_FULL;
                        state_n   = SHIFT;
                    end
                end
                SHIFT: begin
                    if (shift_enable) begin
                        if (cnt == CNT_LAST) begin
                            if (hr_full) begin
                                sr_n      = hr;
                                hr_full_n = 1'b0;
                                cnt_n     = CNT_FULL;
                            end else begin
                                state_n = IDLE;
                                sr_n    = SR_IDLE;
                                cnt_n   = '0;
                            end
                        end else begin
                            sr_n  = sr_shifted;
                            cnt_n = cnt - CNT_LAST;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flex_pts_stream.sv
// tb_flex_pts_stream: drives an MSB-first and an LSB-first instance with the
// same inputs and checks both against a word/bit-index model of the stream.
module tb_flex_pts_stream;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         n_rst;
    logic         in_valid;
    logic [N-1:0] parallel_in;
    logic         shift_enable;
    logic         abort;

    logic rdy_m, ser_m, done_m, busy_m;
    logic rdy_l, ser_l, done_l, busy_l;

    int   n_compared   = 0;
    int   n_mismatched = 0;
    logic check_en     = 1'b0;

    // Model of the stream: the word being sent, how many of its bits have gone
    // out, and an optional buffered word waiting behind it.
    typedef struct packed {
        logic         active;
        logic [N-1:0] word;
        logic [7:0]   sent;
        logic         buf_valid;
        logic [N-1:0] bufw;
    } model_t;

    model_t m;

    flex_pts_stream #(.NUM_BITS(N), .SHIFT_MSB(1'b1), .IDLE_BIT(1'b1)) dut_msb (
        .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(rdy_m),
        .parallel_in(parallel_in), .shift_enable(shift_enable), .abort(abort),
        .serial_out(ser_m), .word_done(done_m), .busy(busy_m)
    );

    flex_pts_stream #(.NUM_BITS(N), .SHIFT_MSB(1'b0), .IDLE_BIT(1'b1)) dut_lsb (
        .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(rdy_l),
        .parallel_in(parallel_in), .shift_enable(shift_enable), .abort(abort),
        .serial_out(ser_l), .word_done(done_l), .busy(busy_l)
    );

    always #5 clk = ~clk;

    function automatic model_t modelNext(input model_t c, input logic v,
                                         input logic [N-1:0] d, input logic se,
                                         input logic ab);
        model_t x;
        logic   take;
        x    = c;
        take = v && !c.buf_valid;
        if (ab) begin
            x.active    = 1'b0;
            x.buf_valid = 1'b0;
            x.sent      = '0;
            return x;
        end
        if (c.active) begin
            if (se) begin
                if (int'(c.sent) == N - 1) begin
                    if (c.buf_valid) begin
                        x.word      = c.bufw;
                        x.buf_valid = 1'b0;
                        x.sent      = '0;
                    end else begin
                        x.active = 1'b0;
                        x.sent   = '0;
                    end
                end else begin
                    x.sent = c.sent + 8'd1;
                end
            end
        end else if (c.buf_valid) begin
            x.active    = 1'b1;
            x.word      = c.bufw;
            x.buf_valid = 1'b0;
            x.sent      = '0;
        end
        if (take) begin
            x.bufw      = d;
            x.buf_valid = 1'b1;
        end
        return x;
    endfunction

    function automatic logic expSerMsb(input model_t c);
        return c.active ? c.word[N - 1 - int'(c.sent)] : 1'b1;
    endfunction

    function automatic logic expSerLsb(input model_t c);
        return c.active ? c.word[int'(c.sent)] : 1'b1;
    endfunction

    function automatic logic expDone(input model_t c, input logic se, input logic ab);
        return c.active && (int'(c.sent) == N - 1) && se && !ab;
    endfunction

    // Advance the model on every clock edge; it resets along with the DUTs.
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) m <= '0;
        else        m <= modelNext(m, in_valid, parallel_in, shift_enable, abort);
    end

    task automatic checkOutput(input string name, input logic act, input logic exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkAll(input string tag, input logic es_m, input logic es_l,
                            input logic er, input logic eb, input logic ed);
        checkOutput({tag, ".ser_msb"},  ser_m,  es_m);
        checkOutput({tag, ".ser_lsb"},  ser_l,  es_l);
        checkOutput({tag, ".rdy_msb"},  rdy_m,  er);
        checkOutput({tag, ".rdy_lsb"},  rdy_l,  er);
        checkOutput({tag, ".busy_msb"}, busy_m, eb);
        checkOutput({tag, ".busy_lsb"}, busy_l, eb);
        checkOutput({tag, ".done_msb"}, done_m, ed);
        checkOutput({tag, ".done_lsb"}, done_l, ed);
    endtask

    // Drive one cycle's inputs just after the edge and return at the mid-cycle sample point.
    task automatic applyStimulus(input logic v, input logic [N-1:0] d,
                                 input logic se, input logic ab);
        @(posedge clk);
        #1;
        in_valid     = v;
        parallel_in  = d;
        shift_enable = se;
        abort        = ab;
        @(negedge clk);
    endtask

    // Compare both DUTs against the model on every cycle once out of the initial reset.
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("mdl.rdy_msb",  rdy_m,  !m.buf_valid);
            checkOutput("mdl.rdy_lsb",  rdy_l,  !m.buf_valid);
            checkOutput("mdl.busy_msb", busy_m, m.active || m.buf_valid);
            checkOutput("mdl.busy_lsb", busy_l, m.active || m.buf_valid);
            checkOutput("mdl.ser_msb",  ser_m,  expSerMsb(m));
            checkOutput("mdl.ser_lsb",  ser_l,  expSerLsb(m));
            checkOutput("mdl.done_msb", done_m, expDone(m, shift_enable, abort));
            checkOutput("mdl.done_lsb", done_l, expDone(m, shift_enable, abort));
        end
    end

    task automatic runWord(input string tag, input logic [N-1:0] data,
                           input logic [7:0] expm, input logic [7:0] expl);
        applyStimulus(1'b1, data, 1'b1, 1'b0);
        checkAll({tag, ".accept"}, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkAll({tag, ".load"}, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
            checkAll($sformatf("%s.bit%0d", tag, i), expm[7-i], expl[7-i], 1'b1, 1'b1, i == 7);
            checkOutput($sformatf("%s.model_msb%0d", tag, i), expSerMsb(m), expm[7-i]);
            checkOutput($sformatf("%s.model_lsb%0d", tag, i), expSerLsb(m), expl[7-i]);
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkAll({tag, ".idle"}, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        logic [15:0]  seq;
        logic [N-1:0] w;

        n_rst        = 1'b0;
        in_valid     = 1'b0;
        parallel_in  = '0;
        shift_enable = 1'b0;
        abort        = 1'b0;

        repeat (2) @(negedge clk);
        checkAll("reset", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        #2;
        n_rst    = 1'b1;
        check_en = 1'b1;
        @(negedge clk);

        // Single words in both bit orders.
        runWord("a5", 8'hA5, 8'hA5, 8'hA5);
        runWord("0f", 8'h0F, 8'h0F, 8'hF0);

        // Second word queued during the first streams out with no gap.
        seq = 16'hA53C;
        applyStimulus(1'b1, 8'hA5, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h3C, 1'b1, 1'b0);
        checkAll("b2b.0", seq[15], seq[15], 1'b1, 1'b1, 1'b0);
        for (int i = 1; i < 16; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
            checkAll($sformatf("b2b.%0d", i), seq[15-i], seq[15-i], i >= 8, 1'b1, (i == 7) || (i == 15));
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkAll("b2b.idle", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        // Slow bit strobe with a third word held at the input while the buffer is full.
        w = 8'hA5;
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        for (int k = 0; k < 32; k++) begin
            applyStimulus(1'b1, (k == 0) ? 8'h3C : 8'h5A, (k % 4) == 3, 1'b0);
            checkAll($sformatf("slow.%0d", k), w[7 - k/4], w[k/4], k == 0, 1'b1, k == 31);
        end
        applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
        checkAll("slow.free", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkAll("slow.took", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkAll("slow.flushed", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        // Abort after three bits with a word buffered: everything is dropped.
        applyStimulus(1'b1, 8'hA5, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h3C, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        checkAll("abort.cycle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int j = 0; j < 12; j++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
            checkAll($sformatf("abort.after%0d", j), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        end

        // Asynchronous reset mid-word with a word buffered.
        applyStimulus(1'b1, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        #2;
        n_rst = 1'b0;
        #1;
        checkAll("rst.async", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checkAll("rst.hold", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        #2;
        n_rst = 1'b1;
        for (int j = 0; j < 10; j++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
            checkAll($sformatf("rst.after%0d", j), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        end

        // Random traffic checked against the model.
        for (int c = 0; c < 3000; c++) begin
            applyStimulus(1'($urandom_range(0, 1)), N'($urandom),
                          $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
        end
        for (int c = 0; c < 2000; c++) begin
            applyStimulus(1'($urandom_range(0, 1)), N'($urandom),
                          $urandom_range(0, 4) == 0, $urandom_range(0, 199) == 0);
        end
        repeat (20) applyStimulus(1'b0, '0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
